// File: rtl/do_while_seq_if.sv
// Handshake bundle for the do-while sequencer.
// The master side represents both the control master (start/limit/abort)
// and the body engine (body_ack), since a single agent usually drives both
// from the outside.
interface do_while_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] limit;
    logic             abort;
    logic             body_req;
    logic             body_ack;
    logic [CNT_W-1:0] iter;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, limit, abort, body_ack,
        input  body_req, iter, busy, done, aborted
    );

    modport slave (
        input  start, limit, abort, body_ack,
        output body_req, iter, busy, done, aborted
    );
endinterface

// File: rtl/do_while_seq.sv
// Do-while loop sequencer: launches the loop body through a req/ack
// handshake, counts completed bodies and only tests iter < limit after a
// body finishes, so the body always executes at least once.
module do_while_seq #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    do_while_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        COND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lim_q,   lim_d;
    logic [CNT_W-1:0] iter_q,  iter_d;
    logic             aborted_q, aborted_d;

    // Next-state logic: abort takes priority over a same-cycle body_ack, and
    // the exit test uses the already-incremented count held in COND.
    always_comb begin
        state_d   = state_q;
        lim_d     = lim_q;
        iter_d    = iter_q;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lim_d   = bus.limit;
                    iter_d  = '0;
                    state_d = BODY;
                end
            end
            BODY: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bus.body_ack) begin
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = COND;
                end
            end
            COND: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (iter_q < lim_q) begin
                    state_d = BODY;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched bound, iteration count and the registered abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            iter_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lim_q     <= lim_d;
            iter_q    <= iter_d;
            aborted_q <= aborted_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign bus.body_req = (state_q == BODY);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.aborted  = aborted_q;
    assign bus.iter     = iter_q;

endmodule

// File: tb/tb_do_while_seq.sv
// Self-checking bench for do_while_seq. Each loop run is described at the
// transaction level (limit, per-body ack delays, optional abort) and expanded
// into a cycle-by-cycle trace of inputs and expected outputs.
module tb_do_while_seq;

    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    do_while_seq_if #(.CNT_W(CNT_W)) bus ();

    do_while_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] limit;
        logic             abort;
        logic             ack;
        logic             eReq;
        logic             eBusy;
        logic             eDone;
        logic             eAbt;
        logic [CNT_W-1:0] eIter;
    } cyc_t;

    cyc_t trace[$];
    int   modelIter  = 0;
    int   passCount  = 0;
    int   checkCount = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Cycle template with expected outputs; inputs idle by default.
    function automatic cyc_t mkCyc(input bit req, input bit busy, input bit dn,
                                   input bit abt, input int it);
        cyc_t c;
        c.start = 1'b0;
        c.limit = CNT_W'($urandom_range(0, 255));
        c.abort = 1'b0;
        c.ack   = 1'b0;
        c.eReq  = req;
        c.eBusy = busy;
        c.eDone = dn;
        c.eAbt  = abt;
        c.eIter = CNT_W'(it);
        return c;
    endfunction

    // Idle cycles after a run: abort and ack are noise and must be ignored.
    task automatic pushIdleTail(input bit abtPulse);
        cyc_t c;
        c = mkCyc(0, 0, 0, abtPulse, modelIter);
        c.abort = 1'($urandom_range(0, 1));
        c.ack   = 1'($urandom_range(0, 1));
        trace.push_back(c);
        c = mkCyc(0, 0, 0, 0, modelIter);
        c.abort = 1'($urandom_range(0, 1));
        trace.push_back(c);
    endtask

    // Expand one run. abortMode: 0 none, 1 abort with ack in body,
    // 2 abort in the exit test, 3 abort in body without ack.
    task automatic buildRun(input int lim, input int dMin, input int dMax,
                            input int abortMode, input int abortIter, input bit noise);
        cyc_t c;
        int   n;
        int   d;
        n = (lim == 0) ? 1 : lim;
        c = mkCyc(0, 0, 0, 0, modelIter);
        c.start = 1'b1;
        c.limit = CNT_W'(lim);
        trace.push_back(c);
        modelIter = 0;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(dMax, dMin);
            for (int s = 0; s < d; s++) begin
                c = mkCyc(1, 1, 0, 0, i);
                if (noise) c.start = 1'($urandom_range(0, 1));
                trace.push_back(c);
            end
            c = mkCyc(1, 1, 0, 0, i);
            if (noise) c.start = 1'($urandom_range(0, 1));
            if ((abortMode == 1 || abortMode == 3) && i == abortIter) begin
                c.abort = 1'b1;
                c.ack   = (abortMode == 1);
                trace.push_back(c);
                modelIter = i;
                pushIdleTail(1'b1);
                return;
            end
            c.ack = 1'b1;
            trace.push_back(c);
            modelIter = i + 1;
            c = mkCyc(0, 1, 0, 0, modelIter);
            c.ack = 1'($urandom_range(0, 1));
            if (noise) c.start = 1'($urandom_range(0, 1));
            if (abortMode == 2 && i == abortIter) begin
                c.abort = 1'b1;
                trace.push_back(c);
                pushIdleTail(1'b1);
                return;
            end
            trace.push_back(c);
        end
        c = mkCyc(0, 1, 1, 0, modelIter);
        c.abort = 1'($urandom_range(0, 1));
        if (noise) c.start = 1'($urandom_range(0, 1));
        trace.push_back(c);
        pushIdleTail(1'b0);
    endtask

    // Replay the trace: drive just after the rising edge, sample on the falling edge.
    task automatic applyStimulus();
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            @(posedge clk);
            #1;
            bus.start    = c.start;
            bus.limit    = c.limit;
            bus.abort    = c.abort;
            bus.body_ack = c.ack;
            @(negedge clk);
            checkOutput("body_req", 32'(bus.body_req), 32'(c.eReq));
            checkOutput("busy",     32'(bus.busy),     32'(c.eBusy));
            checkOutput("done",     32'(bus.done),     32'(c.eDone));
            checkOutput("aborted",  32'(bus.aborted),  32'(c.eAbt));
            checkOutput("iter",     32'(bus.iter),     32'(c.eIter));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},  32'(bus.body_req), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy),     32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done),     32'd0);
        checkOutput({tag, "_abt"},  32'(bus.aborted),  32'd0);
        checkOutput({tag, "_iter"}, 32'(bus.iter),     32'd0);
    endtask

    initial begin
        int lim;
        int n;
        bus.start    = 1'b0;
        bus.limit    = '0;
        bus.abort    = 1'b0;
        bus.body_ack = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Reset asserted during the second body of a limit=5 run.
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.limit    = 8'd5;
        bus.body_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midrst_req_before",  32'(bus.body_req), 32'd1);
        checkOutput("midrst_iter_before", 32'(bus.iter),     32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        bus.body_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midrst_hold");
        rst_n = 1'b1;
        modelIter = 0;

        // Directed runs.
        buildRun(3,   0, 0, 0, 0, 0); applyStimulus();
        buildRun(0,   0, 0, 0, 0, 0); applyStimulus();
        buildRun(1,   0, 0, 0, 0, 0); applyStimulus();
        buildRun(2,   4, 4, 0, 0, 0); applyStimulus();
        buildRun(5,   0, 0, 1, 2, 0); applyStimulus();
        buildRun(4,   0, 1, 0, 0, 1); applyStimulus();
        buildRun(255, 0, 0, 0, 0, 1); applyStimulus();

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) lim = $urandom_range(0, 255);
            else                           lim = $urandom_range(0, 10);
            n = (lim == 0) ? 1 : lim;
            buildRun(lim, 0, (lim > 20) ? 0 : 3, $urandom_range(0, 3),
                     $urandom_range(0, n - 1), 1'b1);
            applyStimulus();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
